// File: rtl/main_mem_ctrl_pkg.sv
// Shared widths, default latency and controller state encoding for the block-memory controller.
package mem_pkg;
  localparam int BLOCK_W     = 128;
  localparam int ADDR_W      = 10;
  localparam int IDX_W       = 6;
  localparam int LATENCY_DEF = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte address to block index; the low nibble selects a byte inside the block and is ignored.
  function automatic logic [IDX_W-1:0] block_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: IDX_W];
  endfunction
endpackage

// File: rtl/main_mem_ctrl_if.sv
// Request/response bus between a requester (master) and the block-memory controller (slave).
interface main_mem_ctrl_if;
  import mem_pkg::*;

  logic               req;
  logic               read_writeIn;
  logic [ADDR_W-1:0]  address;
  logic [BLOCK_W-1:0] writeDataIn;
  logic [BLOCK_W-1:0] readDataOut;
  logic               ready;
  logic               done;

  modport master (
    output req, read_writeIn, address, writeDataIn,
    input  readDataOut, ready, done
  );

  modport slave (
    input  req, read_writeIn, address, writeDataIn,
    output readDataOut, ready, done
  );
endinterface

// File: rtl/main_mem_ctrl_mem_array.sv
// Single-port NUM_BLOCKS x 128 synchronous RAM; read data is registered and held until the next read.
module mem_array
  import mem_pkg::*;
#(
  parameter int NUM_BLOCKS = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [IDX_W-1:0]   idx,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata
);
  logic [BLOCK_W-1:0] mem_q [NUM_BLOCKS];
  logic [BLOCK_W-1:0] rdata_q, rdata_d;

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clock) begin
    if (we) mem_q[idx] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/main_mem_ctrl.sv
// Block-memory controller: one request at a time, array access and done LATENCY edges after accept.
// ready drops on accept and returns the edge after the done pulse; requests seen while busy are dropped.
module main_mem_ctrl
  import mem_pkg::*;
#(
  parameter int LATENCY    = LATENCY_DEF,
  parameter int NUM_BLOCKS = 64
) (
  input logic            clock,
  input logic            reset,
  main_mem_ctrl_if.slave bus
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLOCK_W-1:0] wdat_q, wdat_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               access;
  logic [BLOCK_W-1:0] rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    case (state_q)
      // ready_q gates acceptance so the first edge out of reset cannot take a request.
      ST_IDLE: begin
        if (ready_q && bus.req) begin
          rw_d    = bus.read_writeIn;
          idx_d   = block_idx(bus.address);
          wdat_d  = bus.writeDataIn;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // The array is touched on the same edge that moves BUSY to DONE.
  assign access = (state_q == ST_BUSY) && (cnt_q == '0);

  mem_array #(
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (access && rw_q),
    .re    (access && !rw_q),
    .idx   (idx_q),
    .wdata (wdat_q),
    .rdata (rdata)
  );

  assign bus.readDataOut = rdata;
  assign bus.ready       = ready_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Randomised bench for main_mem_ctrl against a block-array model, plus a LATENCY=2 instance.
module tb_main_mem_ctrl;
  localparam int L  = 4;
  localparam int L2 = 2;

  logic clock;
  logic reset;
  int   edge_no = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [127:0] mdl_mem [64];
  logic [127:0] mdl_rd;

  main_mem_ctrl_if bus ();
  main_mem_ctrl_if bus2 ();

  main_mem_ctrl #(.LATENCY(L), .NUM_BLOCKS(64)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  main_mem_ctrl #(.LATENCY(L2), .NUM_BLOCKS(64)) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edge_no <= edge_no + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One transaction on the L=4 instance; edge numbers are reported for timing checks and the model is updated.
  task automatic issue(input logic rw, input logic [9:0] a, input logic [127:0] d,
                       output int acc_e, output int rise_e, output int fall_e,
                       output logic [127:0] rd, output logic rdy_after);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    bus.req = 1'b1; bus.read_writeIn = rw; bus.address = a; bus.writeDataIn = d;
    @(negedge clock);
    acc_e = edge_no;
    bus.req = 1'b0;
    bus.read_writeIn = 1'($urandom); bus.address = 10'($urandom); bus.writeDataIn = rand128();
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    rise_e = (n < 50) ? edge_no : -1000;
    rd = bus.readDataOut;
    n = 0;
    while (bus.done === 1'b1 && n < 50) begin @(negedge clock); n++; end
    fall_e = edge_no;
    rdy_after = bus.ready;
    if (rw) mdl_mem[a[9:4]] = d;
    else    mdl_rd = mdl_mem[a[9:4]];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 0; bus.read_writeIn = 0; bus.address = 0; bus.writeDataIn = 0;
    bus2.req = 0; bus2.read_writeIn = 0; bus2.address = 0; bus2.writeDataIn = 0;
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    mdl_rd = '0;
    repeat (3) @(negedge clock);
    n_checks++; if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.ready); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else n_pass++;
    n_checks++; if (bus.readDataOut !== 128'h0) $display("FAIL reset_rdata: got %h expected 0", bus.readDataOut); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", bus.ready); else n_pass++;
    n_checks++; if (bus2.ready !== 1'b1) $display("FAIL reset_ready_after_l2: got %b expected 1", bus2.ready); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [127:0] v, rd;
    int acc, rise, fall;
    logic rdy;
    v = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    issue(1'b1, 10'h040, v, acc, rise, fall, rd, rdy);
    n_checks++; if (rise - acc !== L) $display("FAIL wr_latency: got %0d expected %0d", rise - acc, L); else n_pass++;
    n_checks++; if (fall - rise !== 1) $display("FAIL wr_done_width: got %0d expected 1", fall - rise); else n_pass++;
    n_checks++; if (rdy !== 1'b1) $display("FAIL wr_ready_return: got %b expected 1", rdy); else n_pass++;
    n_checks++; if (rd !== 128'h0) $display("FAIL wr_rdata_held: got %h expected 0", rd); else n_pass++;
    issue(1'b0, 10'h04C, 128'h0, acc, rise, fall, rd, rdy);
    n_checks++; if (rise - acc !== L) $display("FAIL rd_latency: got %0d expected %0d", rise - acc, L); else n_pass++;
    n_checks++; if (rd !== v) $display("FAIL rd_back: got %h expected %h", rd, v); else n_pass++;
  endtask

  task automatic test_unwritten();
    logic [127:0] rd;
    int acc, rise, fall;
    logic rdy;
    issue(1'b0, 10'h3F0, rand128(), acc, rise, fall, rd, rdy);
    n_checks++; if (rd !== 128'h0) $display("FAIL unwritten_data: got %h expected 0", rd); else n_pass++;
    n_checks++; if (fall - rise !== 1) $display("FAIL unwritten_done_width: got %0d expected 1", fall - rise); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    logic [127:0] d1, rd;
    int acc, rise, fall, n, bad, extra;
    logic rdy;
    d1 = rand128();
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    bus.req = 1'b1; bus.read_writeIn = 1'b1; bus.address = 10'h100; bus.writeDataIn = d1;
    @(negedge clock);
    acc = edge_no;
    bad = 0; n = 0;
    // Keep hammering with requests to blocks 0x300..0x3EF while busy.
    while (bus.done !== 1'b1 && n < 50) begin
      if (bus.ready !== 1'b0) bad++;
      bus.address = {2'b11, 4'($urandom_range(0, 14)), 4'($urandom)};
      bus.writeDataIn = rand128();
      bus.read_writeIn = 1'($urandom);
      @(negedge clock); n++;
    end
    if (bus.ready !== 1'b0) bad++;
    bus.req = 1'b0;
    n_checks++; if (edge_no - acc !== L) $display("FAIL busy_latency: got %0d expected %0d", edge_no - acc, L); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL busy_ready_low: got %0d cycles with ready high, expected 0", bad); else n_pass++;
    @(negedge clock);
    n_checks++; if (bus.ready !== 1'b1) $display("FAIL busy_ready_k5: got %b expected 1", bus.ready); else n_pass++;
    extra = 0;
    repeat (6) begin @(negedge clock); if (bus.done === 1'b1) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL busy_extra_done: got %0d expected 0", extra); else n_pass++;
    mdl_mem[6'h10] = d1;
    issue(1'b0, 10'h100, 128'h0, acc, rise, fall, rd, rdy);
    n_checks++; if (rd !== d1) $display("FAIL busy_first_data: got %h expected %h", rd, d1); else n_pass++;
    issue(1'b0, 10'h350, 128'h0, acc, rise, fall, rd, rdy);
    n_checks++; if (rd !== mdl_rd) $display("FAIL busy_ignored_untouched: got %h expected %h", rd, mdl_rd); else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [127:0] rd;
    int acc, rise, fall, n, extra;
    logic rdy;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    bus.req = 1'b1; bus.read_writeIn = 1'b1; bus.address = 10'h080; bus.writeDataIn = {128{1'b1}};
    @(posedge clock);
    @(negedge clock);
    bus.req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    n_checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b0)
      $display("FAIL abort_in_reset: got done=%b ready=%b expected 0/0", bus.done, bus.ready); else n_pass++;
    reset = 1'b0;
    mdl_rd = '0;
    n_checks++; if (bus.readDataOut !== 128'h0) $display("FAIL abort_rdata_cleared: got %h expected 0", bus.readDataOut); else n_pass++;
    extra = 0;
    repeat (8) begin @(negedge clock); if (bus.done === 1'b1) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL abort_no_done: got %0d expected 0", extra); else n_pass++;
    issue(1'b0, 10'h080, 128'h0, acc, rise, fall, rd, rdy);
    n_checks++; if (rd !== 128'h0) $display("FAIL abort_not_committed: got %h expected 0", rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] d, rd1, rd2, rd3, e1, e3;
    int a1, r1, f1, a2, r2, f2, a3, r3, f3;
    logic rdy;
    d  = rand128();
    e1 = mdl_mem[6'h04];
    e3 = mdl_mem[6'h10];
    issue(1'b0, 10'h045, 128'h0, a1, r1, f1, rd1, rdy);
    issue(1'b1, 10'h2A3, d, a2, r2, f2, rd2, rdy);
    issue(1'b0, 10'h10F, 128'h0, a3, r3, f3, rd3, rdy);
    n_checks++; if (r2 - f1 !== L + 1) $display("FAIL b2b_gap1: got %0d expected %0d", r2 - f1, L + 1); else n_pass++;
    n_checks++; if (r3 - f2 !== L + 1) $display("FAIL b2b_gap2: got %0d expected %0d", r3 - f2, L + 1); else n_pass++;
    n_checks++; if (rd1 !== e1) $display("FAIL b2b_read1: got %h expected %h", rd1, e1); else n_pass++;
    n_checks++; if (rd2 !== e1) $display("FAIL b2b_write_holds: got %h expected %h", rd2, e1); else n_pass++;
    n_checks++; if (rd3 !== e3) $display("FAIL b2b_read2: got %h expected %h", rd3, e3); else n_pass++;
  endtask

  task automatic test_latency2();
    logic [127:0] d;
    logic [3:0] dn;
    logic rdy3;
    int n;
    d = rand128();
    for (int t = 0; t < 2; t++) begin
      n = 0;
      while (bus2.ready !== 1'b1 && n < 50) begin @(negedge clock); n++; end
      bus2.req = 1'b1; bus2.read_writeIn = (t == 0); bus2.address = (t == 0) ? 10'h1C4 : 10'h1CB;
      bus2.writeDataIn = (t == 0) ? d : 128'h0;
      @(negedge clock);
      bus2.req = 1'b0;
      dn = '0;
      for (int j = 1; j <= 3; j++) begin @(negedge clock); dn[j] = bus2.done; end
      rdy3 = bus2.ready;
      n_checks++; if (dn[3:1] !== 3'b010) $display("FAIL l2_done_shape%0d: got %b expected 010", t, dn[3:1]); else n_pass++;
      n_checks++; if (rdy3 !== 1'b1) $display("FAIL l2_ready%0d: got %b expected 1", t, rdy3); else n_pass++;
    end
    n_checks++; if (bus2.readDataOut !== d) $display("FAIL l2_data: got %h expected %h", bus2.readDataOut, d); else n_pass++;
  endtask

  task automatic test_random();
    logic [127:0] rd;
    logic [9:0] a;
    logic rw, rdy;
    int acc, rise, fall;
    for (int i = 0; i < 24; i++) begin
      rw = 1'($urandom);
      a  = {2'b01, 4'($urandom_range(0, 7)), 4'($urandom)};
      issue(rw, a, rand128(), acc, rise, fall, rd, rdy);
      n_checks++; if (rise - acc !== L) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, rise - acc, L); else n_pass++;
      n_checks++; if (rd !== mdl_rd) $display("FAIL rand_data[%0d]: got %h expected %h", i, rd, mdl_rd); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_unwritten();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_latency2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
